// File: rtl/cons_comma_cmp.sv
// Per-clock comma detector for an N-octet word: lowest comma position and all-comma flag, 1-cycle registered.
// Optional HIT output (at least one comma) is enabled by defining CONS_COMMA_CMP_HIT_EN.
module cons_comma_cmp #(
  parameter int         N     = 2,
  parameter logic [7:0] COMMA = 8'b00111101,
  localparam int        DW    = $clog2(N)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N-1:0]        K,
  input  logic [N-1:0][7:0]   DI,
  output logic                CONSEC,
`ifdef CONS_COMMA_CMP_HIT_EN
  output logic                HIT,
`endif
  output logic [DW-1:0]       DO
);

  logic [N-1:0]  m;
  logic [DW-1:0] first;

  always_comb begin
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = K[i] && (DI[i] == COMMA);
    end
  end

  // Scanning from the top down lets the lowest matching octet win.
  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (m[i]) first = DW'(i);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CONSEC <= 1'b0;
      DO     <= '0;
    end else begin
      CONSEC <= &m;
      if (|m) DO <= first;
    end
  end

`ifdef CONS_COMMA_CMP_HIT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) HIT <= 1'b0;
    else     HIT <= |m;
  end
`endif

endmodule

// File: tb/tb_cons_comma_cmp.sv
// Scoreboard bench for cons_comma_cmp with N=2 and the default comma code.
module tb_cons_comma_cmp;

  localparam logic [7:0] CM = 8'h3D;

  logic             CLK;
  logic             RST;
  logic [1:0]       K;
  logic [1:0][7:0]  DI;
  logic             CONSEC;
  logic [0:0]       DO;
`ifdef CONS_COMMA_CMP_HIT_EN
  logic             HIT;
`endif

  cons_comma_cmp #(.N(2), .COMMA(CM)) dut (
    .CLK(CLK),
    .RST(RST),
    .K(K),
    .DI(DI),
    .CONSEC(CONSEC),
`ifdef CONS_COMMA_CMP_HIT_EN
    .HIT(HIT),
`endif
    .DO(DO)
  );

  typedef struct packed {
    logic consec;
    logic dox;
    logic hit;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic model_do = 1'b0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input exp_t e);
    chk({tag, ".consec"}, {31'd0, CONSEC}, {31'd0, e.consec});
    chk({tag, ".do"},     {31'd0, DO},     {31'd0, e.dox});
`ifdef CONS_COMMA_CMP_HIT_EN
    chk({tag, ".hit"},    {31'd0, HIT},    {31'd0, e.hit});
`endif
  endtask

  // Independent reference: match each octet, pick the lowest index, hold on no match.
  task automatic apply(input string tag, input logic [1:0] k, input logic [7:0] d1, input logic [7:0] d0);
    exp_t e;
    logic m0, m1;
    @(negedge CLK);
    K  = k;
    DI = {d1, d0};
    m0 = k[0] && (d0 == CM);
    m1 = k[1] && (d1 == CM);
    if (m0)      model_do = 1'b0;
    else if (m1) model_do = 1'b1;
    e.consec = m0 && m1;
    e.dox    = model_do;
    e.hit    = m0 || m1;
    q.push_back(e);
    @(posedge CLK);
    #1;
    if (q.size() == 0) begin
      chk({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check_outs(tag, e);
    end
  endtask

  initial begin
    exp_t zero;
    logic [1:0] rk;
    logic [7:0] r0, r1;
    zero = '0;
    RST = 1'b1;
    K   = 2'b11;
    DI  = {CM, CM};
    #3;
    check_outs("reset", zero);

    // Held reset ignores comma-laden inputs across edges.
    repeat (2) @(posedge CLK);
    #1;
    check_outs("reset_held", zero);

    // Release between edges; the next edge samples normally.
    @(negedge CLK);
    #2 RST = 1'b0;
    model_do = 1'b0;

    apply("oct0",     2'b01, 8'hA5, CM);
    apply("oct1",     2'b10, CM,    8'h12);
    apply("no_match", 2'b00, CM,    CM);
    apply("both",     2'b11, CM,    CM);
    apply("oct1b",    2'b10, CM,    8'h00);
    apply("k285",     2'b11, CM,    8'hBC);
    apply("data_cm",  2'b00, 8'h00, CM);
    apply("k_nocm",   2'b11, 8'hBC, 8'h7C);

    // Asynchronous assertion mid-cycle clears outputs before any edge.
    apply("pre_rst",  2'b11, CM, CM);
    @(negedge CLK);
    #1 RST = 1'b1;
    #1;
    check_outs("async_rst", zero);
    @(posedge CLK);
    #1;
    check_outs("rst_edge", zero);
    @(negedge CLK);
    RST = 1'b0;
    model_do = 1'b0;

    apply("after_rst", 2'b10, CM, 8'h55);

    for (int i = 0; i < 40; i++) begin
      rk = 2'($urandom_range(0, 3));
      r0 = ($urandom_range(0, 1) == 1) ? CM : 8'($urandom);
      r1 = ($urandom_range(0, 1) == 1) ? CM : 8'($urandom);
      apply("rand", rk, r1, r0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
